mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have no parameters; data and address widths are fixed at 32 bits, register specifiers at 5 bits.
REQ-002 Ports SHALL be:
  clock  in  1  single clock, all state on rising edge
  reset  in  1  synchronous, active-high reset
  ex_valid  in  1  EX outputs hold a live instruction
  ex_result  in  32  ALU result, or effective address for load/store
  ex_result_2  in  32  forwarded store data
  ex_dest_reg  in  5  destination register
  ex_dest_reg_valid  in  1  instruction writes ex_dest_reg
  ex_inval_dest_reg  in  1  suppress write (MOVZ/MOVN fail)
  ex_load_inst  in  1  load
  ex_store_inst  in  1  store
  ex_mem_size  in  2  mem_size_t: SIZE_BYTE, SIZE_HALF, SIZE_WORD
  ex_load_u  in  1  zero-extend load (LBU/LHU)
  stall  out  1  EX/ID must hold their current instruction
  dmem_req  out  1  data memory request
  dmem_we  out  1  request is a write
  dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
  dmem_be  out  4  byte enables, be[3]=bits 31:24
  dmem_wdata  out  32  write data, lane-replicated
  dmem_ack  in  1  request completes this cycle; rdata valid
  dmem_rdata  in  32  read word
  ex_mem_result  out  32  EX/MEM-register result, to EX forwarding
  ex_mem_dest_reg  out  5  EX/MEM destination
  ex_mem_dest_reg_valid  out  1  EX/MEM forwardable write pending
  wb_result  out  32  MEM/WB result
  wb_dest_reg  out  5  MEM/WB destination
  wb_dest_reg_valid  out  1  MEM/WB register-file write enable
  addr_err  out  1  one-cycle misaligned-access pulse

Function
REQ-003 EX/MEM register SHALL capture all ex_* inputs on every edge where stall=0; its valid bit SHALL be ex_valid, and its dest-valid SHALL be ex_dest_reg_valid & ~ex_inval_dest_reg.
REQ-004 FSM states SHALL be IDLE and ACCESS; IDLE->ACCESS when the captured instruction is an aligned load/store; ACCESS->IDLE on dmem_ack=1; ACCESS holds otherwise.
REQ-005 dmem_req SHALL be 1 exactly while in ACCESS; dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL stay constant throughout ACCESS.
REQ-006 stall SHALL equal (state==ACCESS) & ~dmem_ack; a zero-wait memory (ack in first ACCESS cycle) SHALL cost no stall cycle.
REQ-007 Non-memory instructions SHALL reach MEM/WB one edge after EX/MEM capture with wb_result = captured ex_result.
REQ-008 Loads SHALL load MEM/WB on the ack edge; while stall=1, MEM/WB SHALL load a bubble (wb_dest_reg_valid=0).
REQ-009 Byte order SHALL be big-endian: byte offset k occupies bits [31-8k:24-8k]; byte be = 4'b1000>>k; half be = 4'b1100 (offset 0) or 4'b0011 (offset 2); word be = 4'b1111.
REQ-010 Store data SHALL be replicated: byte -> {4{d[7:0]}}, half -> {2{d[15:0]}}, word -> d.
REQ-011 Load data SHALL be the selected lane, sign-extended, or zero-extended when load_u=1.
REQ-012 Half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no request, pulse addr_err for one cycle after capture, and clear dest-valid.
REQ-013 ex_mem_dest_reg_valid SHALL be 0 for a captured load (load-use is handled by the hazard unit), otherwise equal the EX/MEM dest-valid and valid bit.
REQ-014 Stores SHALL produce wb_dest_reg_valid=0.
REQ-015 On the ack edge with stall=0, a new EX instruction SHALL be captured in the same edge.

Reset
REQ-016 With reset=1 at an edge, state SHALL go to IDLE, all valid bits, dmem_req and addr_err to 0, and data registers to 0, including when asserted mid-ACCESS; the outstanding request SHALL be dropped.

Structure
REQ-017 mem_size_t and the state enum SHALL live in pipTypes.
REQ-018 Lane steering (be/wdata generation and load extraction/extension) SHALL be one combinational sub-module, mem_align.

Verification
REQ-019 ADD result 0x1234, dest r5 -> wb_result 0x1234, wb_dest_reg 5 two edges after EX, no stall.
REQ-020 LB addr 0x103, rdata 0x000000F0, ack after 3 cycles -> dmem_addr 0x100, be 0001, stall high 3 cycles, wb_result 0xFFFFFFF0; LBU -> 0x000000F0.
REQ-021 SH addr 0x102, data 0xABCD -> be 0011, wdata 0xABCDABCD, we=1, wb_dest_reg_valid=0.
REQ-022 LW addr 0x101 -> no dmem_req, addr_err one cycle, wb_dest_reg_valid=0.
REQ-023 Reset during ACCESS -> next cycle dmem_req=0, stall=0, state IDLE, all valid outputs 0.
REQ-024 MOVZ with ex_inval_dest_reg=1 -> ex_mem_dest_reg_valid=0 and wb_dest_reg_valid=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: access size, FSM state, and the
// alignment rule used by both the pipeline register and the request FSM.
package pipTypes;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   function automatic logic misaligned(input mem_size_t size, input logic [1:0] off);
      return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Big-endian lane steering: store byte enables and replicated write data,
// and load lane extraction with sign or zero extension.
module mem_align
   import pipTypes::*;
(
   input  mem_size_t   size,
   input  logic [1:0]  offset,
   input  logic        load_u,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      be        = 4'b1111;
      wdata     = store_data;
      load_data = rdata;
      // offset 0 is the most significant byte
      case (offset)
         2'd0:    lane_b = rdata[31:24];
         2'd1:    lane_b = rdata[23:16];
         2'd2:    lane_b = rdata[15:8];
         default: lane_b = rdata[7:0];
      endcase
      lane_h = offset[1] ? rdata[15:0] : rdata[31:16];
      case (size)
         SIZE_BYTE: begin
            be        = 4'b1000 >> offset;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{~load_u & lane_b[7]}}, lane_b};
         end
         SIZE_HALF: begin
            be        = offset[1] ? 4'b0011 : 4'b1100;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{~load_u & lane_h[15]}}, lane_h};
         end
         default: begin
            be        = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers plus a two-state data
// memory handshake that stalls the front end until the access is acked.
module mem_stage
   import pipTypes::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_result,
   input  logic [31:0] ex_result_2,
   input  logic [4:0]  ex_dest_reg,
   input  logic        ex_dest_reg_valid,
   input  logic        ex_inval_dest_reg,
   input  logic        ex_load_inst,
   input  logic        ex_store_inst,
   input  mem_size_t   ex_mem_size,
   input  logic        ex_load_u,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ex_mem_result,
   output logic [4:0]  ex_mem_dest_reg,
   output logic        ex_mem_dest_reg_valid,
   output logic [31:0] wb_result,
   output logic [4:0]  wb_dest_reg,
   output logic        wb_dest_reg_valid,
   output logic        addr_err
);

   logic        m_valid, m_dest_valid, m_load, m_store, m_load_u;
   logic [31:0] m_result, m_result_2;
   logic [4:0]  m_dest;
   mem_size_t   m_size;
   state_t      state, state_nx;
   logic        ex_mem_op, ex_mis, ex_access;
   logic [3:0]  be;
   logic [31:0] wdata, load_data;

   assign ex_mem_op = ex_valid & (ex_load_inst | ex_store_inst);
   assign ex_mis    = ex_mem_op & misaligned(ex_mem_size, ex_result[1:0]);
   assign ex_access = ex_mem_op & ~ex_mis;
   assign stall     = (state == ACCESS) & ~dmem_ack;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // The request starts on the capture edge so EX/MEM never advances past
   // an unissued access; an ack edge may chain straight into the next one.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ex_access) state_nx = ACCESS;
         ACCESS:  if (dmem_ack)  state_nx = ex_access ? ACCESS : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         m_valid      <= 1'b0;
         m_dest_valid <= 1'b0;
         m_load       <= 1'b0;
         m_store      <= 1'b0;
         m_load_u     <= 1'b0;
         m_result     <= '0;
         m_result_2   <= '0;
         m_dest       <= '0;
         m_size       <= SIZE_BYTE;
         addr_err     <= 1'b0;
      end else begin
         addr_err <= ~stall & ex_mis;
         if (!stall) begin
            m_valid      <= ex_valid;
            m_dest_valid <= ex_dest_reg_valid & ~ex_inval_dest_reg & ~ex_mis;
            m_load       <= ex_load_inst;
            m_store      <= ex_store_inst;
            m_load_u     <= ex_load_u;
            m_result     <= ex_result;
            m_result_2   <= ex_result_2;
            m_dest       <= ex_dest_reg;
            m_size       <= ex_mem_size;
         end
      end
   end

   mem_align u_align (
      .size       (m_size),
      .offset     (m_result[1:0]),
      .load_u     (m_load_u),
      .store_data (m_result_2),
      .rdata      (dmem_rdata),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         wb_result         <= '0;
         wb_dest_reg       <= '0;
         wb_dest_reg_valid <= 1'b0;
      end else if (stall) begin
         wb_dest_reg_valid <= 1'b0;
      end else begin
         wb_result         <= m_load ? load_data : m_result;
         wb_dest_reg       <= m_dest;
         wb_dest_reg_valid <= m_valid & m_dest_valid & ~m_store;
      end
   end

   assign dmem_req              = (state == ACCESS);
   assign dmem_we               = dmem_req & m_store;
   assign dmem_addr             = {m_result[31:2], 2'b00};
   assign dmem_be               = be;
   assign dmem_wdata            = wdata;
   assign ex_mem_result         = m_result;
   assign ex_mem_dest_reg       = m_dest;
   assign ex_mem_dest_reg_valid = m_valid & m_dest_valid & ~m_load;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction scoreboards for memory requests
// and register writebacks, plus hand-computed checks on the key scenarios.
module tb_mem_stage;
   import pipTypes::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_dest_reg_valid, ex_inval_dest_reg;
   logic        ex_load_inst, ex_store_inst, ex_load_u;
   logic [31:0] ex_result, ex_result_2;
   logic [4:0]  ex_dest_reg;
   mem_size_t   ex_mem_size;
   logic        stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] ex_mem_result, wb_result;
   logic [4:0]  ex_mem_dest_reg, wb_dest_reg;
   logic        ex_mem_dest_reg_valid, wb_dest_reg_valid, addr_err;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waitc;
   } req_t;
   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
   } wb_t;

   req_t req_q[$];
   wb_t  wb_q[$];
   int   n_chk = 0, n_fail = 0;
   int   err_exp = 0, err_seen = 0, stall_cyc = 0;

   mem_stage dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
      .ex_result_2(ex_result_2), .ex_dest_reg(ex_dest_reg),
      .ex_dest_reg_valid(ex_dest_reg_valid), .ex_inval_dest_reg(ex_inval_dest_reg),
      .ex_load_inst(ex_load_inst), .ex_store_inst(ex_store_inst),
      .ex_mem_size(ex_mem_size), .ex_load_u(ex_load_u), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .ex_mem_result(ex_mem_result),
      .ex_mem_dest_reg(ex_mem_dest_reg), .ex_mem_dest_reg_valid(ex_mem_dest_reg_valid),
      .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
      .wb_dest_reg_valid(wb_dest_reg_valid), .addr_err(addr_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference rules written straight from the big-endian lane definition.
   function automatic logic [3:0] exp_be(input mem_size_t sz, input logic [1:0] off);
      if (sz == SIZE_BYTE) return 4'(8 >> off);
      if (sz == SIZE_HALF) return (off == 2'd2) ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] exp_wdata(input mem_size_t sz, input logic [31:0] d);
      if (sz == SIZE_BYTE) return (d & 32'hFF) * 32'h01010101;
      if (sz == SIZE_HALF) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input mem_size_t sz, input logic [1:0] off,
                                            input logic [31:0] rd, input logic u);
      logic [31:0] v;
      if (sz == SIZE_BYTE) begin
         v = (rd >> (8 * (3 - int'(off)))) & 32'hFF;
         if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (sz == SIZE_HALF) begin
         v = (off == 2'd2) ? (rd & 32'hFFFF) : (rd >> 16);
         if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   task automatic bubble();
      ex_valid = 0; ex_result = 0; ex_result_2 = 0; ex_dest_reg = 0;
      ex_dest_reg_valid = 0; ex_inval_dest_reg = 0; ex_load_inst = 0;
      ex_store_inst = 0; ex_mem_size = SIZE_BYTE; ex_load_u = 0;
   endtask

   // Records the expected outcome, presents the instruction and holds it
   // until the stage accepts it; returns just after the capture edge.
   task automatic issue(input logic ld, input logic st, input mem_size_t sz, input logic u,
                        input logic [31:0] res, input logic [31:0] d2, input logic [4:0] dst,
                        input logic dv, input logic inv, input int w, input logic [31:0] rd);
      logic mis;
      int   g;
      req_t r;
      wb_t  b;
      mis = (ld || st) && ((sz == SIZE_HALF && res[0]) || (sz == SIZE_WORD && res[1:0] != 2'b00));
      if ((ld || st) && !mis) begin
         r.we = st; r.addr = res & 32'hFFFFFFFC; r.be = exp_be(sz, res[1:0]);
         r.wdata = exp_wdata(sz, d2); r.rdata = rd; r.waitc = w;
         req_q.push_back(r);
      end
      if (mis) err_exp++;
      if (!st && dv && !inv && !mis) begin
         b.res = ld ? exp_load(sz, res[1:0], rd, u) : res;
         b.dest = dst;
         wb_q.push_back(b);
      end
      @(negedge clock);
      ex_valid = 1; ex_result = res; ex_result_2 = d2; ex_dest_reg = dst;
      ex_dest_reg_valid = dv; ex_inval_dest_reg = inv; ex_load_inst = ld;
      ex_store_inst = st; ex_mem_size = sz; ex_load_u = u;
      #1;
      g = 0;
      while (stall && g < 200) begin
         @(negedge clock); #1; g++;
      end
      if (g >= 200) chk("issue_timeout", 32'(g), 32'd0);
      @(posedge clock); #1;
      bubble();
   endtask

   task automatic wait_wb(input string name);
      int g;
      g = 0;
      while (!wb_dest_reg_valid && g < 30) begin
         @(posedge clock); #1; g++;
      end
      chk(name, 32'(wb_dest_reg_valid), 32'd1);
   endtask

   // Memory model: acks the head request after its programmed wait count.
   initial begin
      int cnt;
      cnt = 0; dmem_ack = 0; dmem_rdata = 0;
      forever begin
         @(negedge clock);
         if (dmem_req && req_q.size() > 0) begin
            if (cnt >= req_q[0].waitc) begin
               dmem_ack = 1; dmem_rdata = req_q[0].rdata; cnt = 0;
            end else begin
               dmem_ack = 0; cnt++;
            end
         end else begin
            dmem_ack = 0; cnt = 0;
         end
      end
   end

   // Per-cycle comparison against the scoreboards.
   initial begin
      logic prev_err;
      prev_err = 0;
      forever begin
         @(negedge clock); #2;
         if (!reset) begin
            chk("stall_rule", 32'(stall), 32'(dmem_req & ~dmem_ack));
            if (stall) stall_cyc++;
            if (dmem_req) begin
               if (req_q.size() == 0) chk("unexpected_req", 32'(dmem_req), 32'd0);
               else begin
                  chk("req_we", 32'(dmem_we), 32'(req_q[0].we));
                  chk("req_addr", dmem_addr, req_q[0].addr);
                  chk("req_be", 32'(dmem_be), 32'(req_q[0].be));
                  if (req_q[0].we) chk("req_wdata", dmem_wdata, req_q[0].wdata);
                  if (dmem_ack) void'(req_q.pop_front());
               end
            end
            if (wb_dest_reg_valid) begin
               if (wb_q.size() == 0) chk("unexpected_wb", 32'(wb_dest_reg_valid), 32'd0);
               else begin
                  chk("wb_result", wb_result, wb_q[0].res);
                  chk("wb_dest", 32'(wb_dest_reg), 32'(wb_q[0].dest));
                  void'(wb_q.pop_front());
               end
            end
            if (addr_err) begin
               err_seen++;
               if (prev_err) chk("addr_err_width", 32'(prev_err), 32'd0);
            end
            prev_err = addr_err;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, n_chk=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      bubble();
      reset = 1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_dest_reg_valid), 32'd0);
      chk("rst_exmem_valid", 32'(ex_mem_dest_reg_valid), 32'd0);
      chk("rst_wb_result", wb_result, 32'd0);
      chk("rst_addr_err", 32'(addr_err), 32'd0);
      @(negedge clock); reset = 0;

      // ADD r5 = 0x1234: forwardable after capture, written back one edge later
      issue(0, 0, SIZE_WORD, 0, 32'h1234, 0, 5'd5, 1, 0, 0, 0);
      chk("add_fwd_valid", 32'(ex_mem_dest_reg_valid), 32'd1);
      chk("add_fwd_result", ex_mem_result, 32'h1234);
      chk("add_no_stall", 32'(stall), 32'd0);
      @(posedge clock); #1;
      chk("add_wb_valid", 32'(wb_dest_reg_valid), 32'd1);
      chk("add_wb_result", wb_result, 32'h1234);
      chk("add_wb_dest", 32'(wb_dest_reg), 32'd5);

      // LB 0x103, three wait cycles
      stall_cyc = 0;
      issue(1, 0, SIZE_BYTE, 0, 32'h103, 0, 5'd8, 1, 0, 3, 32'h000000F0);
      chk("lb_req", 32'(dmem_req), 32'd1);
      chk("lb_addr", dmem_addr, 32'h100);
      chk("lb_be", 32'(dmem_be), 32'b0001);
      chk("lb_fwd_suppressed", 32'(ex_mem_dest_reg_valid), 32'd0);
      wait_wb("lb_wb_seen");
      chk("lb_result", wb_result, 32'hFFFFFFF0);
      chk("lb_stall_cycles", 32'(stall_cyc), 32'd3);

      issue(1, 0, SIZE_BYTE, 1, 32'h103, 0, 5'd9, 1, 0, 3, 32'h000000F0);
      wait_wb("lbu_wb_seen");
      chk("lbu_result", wb_result, 32'h000000F0);

      // SH 0x102, zero-wait memory
      stall_cyc = 0;
      issue(0, 1, SIZE_HALF, 0, 32'h102, 32'h0000ABCD, 5'd0, 0, 0, 0, 0);
      chk("sh_be", 32'(dmem_be), 32'b0011);
      chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
      chk("sh_we", 32'(dmem_we), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         chk("sh_wb_valid", 32'(wb_dest_reg_valid), 32'd0);
      end
      chk("sh_stall_cycles", 32'(stall_cyc), 32'd0);

      // LW 0x101: misaligned
      issue(1, 0, SIZE_WORD, 0, 32'h101, 0, 5'd4, 1, 0, 0, 0);
      chk("lw_mis_err", 32'(addr_err), 32'd1);
      chk("lw_mis_req", 32'(dmem_req), 32'd0);
      @(posedge clock); #1;
      chk("lw_mis_err_end", 32'(addr_err), 32'd0);
      chk("lw_mis_wb", 32'(wb_dest_reg_valid), 32'd0);

      // MOVZ with failed condition
      issue(0, 0, SIZE_WORD, 0, 32'h55, 0, 5'd7, 1, 1, 0, 0);
      chk("movz_fwd", 32'(ex_mem_dest_reg_valid), 32'd0);
      @(posedge clock); #1;
      chk("movz_wb", 32'(wb_dest_reg_valid), 32'd0);

      // Back-to-back: loads chained on ack edges, then ALU, then SB/LHU/SH misaligned
      issue(1, 0, SIZE_WORD, 0, 32'h200, 0, 5'd10, 1, 0, 2, 32'hDEADBEEF);
      issue(1, 0, SIZE_HALF, 0, 32'h202, 0, 5'd11, 1, 0, 1, 32'h00008001);
      issue(0, 0, SIZE_WORD, 0, 32'h77, 0, 5'd3, 1, 0, 0, 0);
      issue(0, 1, SIZE_BYTE, 0, 32'h201, 32'h1234565A, 5'd0, 0, 0, 0, 0);
      issue(1, 0, SIZE_HALF, 1, 32'h200, 0, 5'd12, 1, 0, 1, 32'h80011234);
      issue(0, 1, SIZE_HALF, 0, 32'h203, 32'h1111, 5'd0, 0, 0, 0, 0);
      issue(0, 1, SIZE_WORD, 0, 32'h300, 32'hCAFEF00D, 5'd0, 0, 0, 2, 0);
      repeat (6) @(posedge clock);
      #1;

      // Reset while an access is outstanding
      issue(1, 0, SIZE_WORD, 0, 32'h400, 0, 5'd13, 1, 0, 100, 0);
      @(negedge clock); #3;
      chk("pre_rst_req", 32'(dmem_req), 32'd1);
      chk("pre_rst_stall", 32'(stall), 32'd1);
      reset = 1;
      @(posedge clock); #1;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_wb_valid", 32'(wb_dest_reg_valid), 32'd0);
      chk("mid_rst_fwd_valid", 32'(ex_mem_dest_reg_valid), 32'd0);
      chk("mid_rst_addr_err", 32'(addr_err), 32'd0);
      req_q.delete();
      wb_q.delete();
      reset = 0;

      // Stage must be idle again: ALU op flows without stall
      issue(0, 0, SIZE_WORD, 0, 32'h9999, 0, 5'd2, 1, 0, 0, 0);
      chk("post_rst_no_req", 32'(dmem_req), 32'd0);
      @(posedge clock); #1;
      chk("post_rst_wb", wb_result, 32'h9999);
      repeat (3) @(posedge clock);
      #3;

      chk("req_q_drained", 32'(req_q.size()), 32'd0);
      chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
      chk("addr_err_count", 32'(err_seen), 32'(err_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
